// File: rtl/seq_ctrl_if.sv
// Request and control-strobe bundle between the sequencer and its requester/datapath.
// state_dbg mirrors the phase FSM so checkers can observe it without probing internals.
interface seq_ctrl_if #(
   parameter int CNT_W   = 8,
   parameter int STEP_W  = 2,
   parameter int DWELL_W = 3
);
   logic [1:0]         on;
   logic               start;
   logic [CNT_W-1:0]   len;
   logic [STEP_W-1:0]  step_cfg;
   logic [DWELL_W-1:0] dwell;
   logic [1:0]         regime;
   logic               active;
   logic               done;
   logic [1:0]         y_select_next;
   logic [STEP_W-1:0]  s_step;
   logic               y_en;
   logic               s_en;
   logic               y_store_x;
   logic               s_add;
   logic               s_zero;
   logic [CNT_W-1:0]   iter;
   logic [2:0]         state_dbg;

   // Handshake: start is a level request, sampled only while idle; done is a
   // one-cycle pulse and needs no acknowledge.
   modport master (
      output on, start, len, step_cfg, dwell,
      input  regime, active, done, y_select_next, s_step, y_en, s_en,
             y_store_x, s_add, s_zero, iter, state_dbg
   );

   modport slave (
      input  on, start, len, step_cfg, dwell,
      output regime, active, done, y_select_next, s_step, y_en, s_en,
             y_store_x, s_add, s_zero, iter, state_dbg
   );
endinterface

// File: rtl/seq_ctrl_gen.sv
// Phase/regime sequencer generating datapath strobes for ELIST/CNT/UPDATE runs.
// Optional macro SEQ_CTRL_AUTO_RESTART_EN: restart straight from DONE while start is held.
module seq_ctrl_gen #(
   parameter int CNT_W   = 8,
   parameter int STEP_W  = 2,
   parameter int DWELL_W = 3
) (
   input logic       clk,
   input logic       rst,
   seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_IDLE = 3'd1,
      ST_INIT = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         regime_q, regime_d;
   logic [CNT_W-1:0]   iter_q, iter_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] timer_q, timer_d;
   logic [DWELL_W-1:0] reload;
   logic               tick;
   logic               restart;

   // A dwell of 0 behaves like 1: every RUN cycle is an enable cycle.
   assign reload = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
   assign tick   = (state_q == ST_RUN) && (timer_q == '0);

`ifdef SEQ_CTRL_AUTO_RESTART_EN
   assign restart = bus.start && (bus.on == regime_q);
`else
   assign restart = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_OFF;
         regime_q <= '0;
         iter_q   <= '0;
         len_q    <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         regime_q <= regime_d;
         iter_q   <= iter_d;
         len_q    <= len_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      regime_d = regime_q;
      iter_d   = iter_q;
      len_d    = len_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      timer_d  = timer_q;
      // on==0 always wins and drops to OFF with iter frozen and no done pulse.
      if (state_q != ST_OFF && bus.on == 2'd0) begin
         state_d  = ST_OFF;
         regime_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (bus.on != 2'd0) begin
                  state_d  = ST_IDLE;
                  regime_d = bus.on;
               end
            end
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_INIT;
                  len_d   = bus.len;
                  step_d  = bus.step_cfg;
                  dwell_d = bus.dwell;
               end else begin
                  regime_d = bus.on;
               end
            end
            ST_INIT: begin
               iter_d  = '0;
               timer_d = reload;
               state_d = (len_q != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
               if (tick) begin
                  iter_d  = iter_q + CNT_W'(1);
                  timer_d = reload;
                  if (iter_q == len_q - CNT_W'(1)) state_d = ST_DONE;
               end else begin
                  timer_d = timer_q - DWELL_W'(1);
               end
            end
            ST_DONE: begin
               if (restart) begin
                  state_d = ST_INIT;
                  len_d   = bus.len;
                  step_d  = bus.step_cfg;
                  dwell_d = bus.dwell;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d  = ST_OFF;
               regime_d = '0;
            end
         endcase
      end
   end

   assign bus.regime    = regime_q;
   assign bus.iter      = iter_q;
   assign bus.state_dbg = state_q;

   always_comb begin
      bus.active        = 1'b0;
      bus.done          = 1'b0;
      bus.y_select_next = 2'd0;
      bus.s_step        = '0;
      bus.y_en          = 1'b0;
      bus.s_en          = 1'b0;
      bus.y_store_x     = 1'b0;
      bus.s_add         = 1'b0;
      bus.s_zero        = 1'b0;
      case (state_q)
         ST_INIT: begin
            bus.active    = 1'b1;
            bus.y_store_x = 1'b1;
            bus.y_en      = 1'b1;
            bus.s_zero    = 1'b1;
            bus.s_en      = 1'b1;
         end
         ST_RUN: begin
            bus.active = 1'b1;
            bus.y_en   = tick;
            bus.s_en   = tick;
            case (regime_q)
               2'd1: begin
                  bus.y_select_next = 2'd1;
                  bus.s_add         = 1'b1;
                  bus.s_step        = step_q;
               end
               2'd2: begin
                  bus.y_select_next = 2'd2;
                  bus.s_add         = 1'b1;
                  bus.s_step        = STEP_W'(1);
               end
               2'd3: begin
                  bus.y_select_next = 2'd3;
                  bus.s_add         = 1'b0;
                  bus.s_step        = step_q;
               end
               default: ;
            endcase
         end
         ST_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_ctrl_gen.sv
// Directed bench for seq_ctrl_gen: a cycle model built from run/iteration counts
// is compared against every output each cycle, plus hand-computed scenario results.
module tb_seq_ctrl_gen;
   localparam int CNT_W   = 8;
   localparam int STEP_W  = 2;
   localparam int DWELL_W = 3;

   localparam int P_OFF  = 0;
   localparam int P_IDLE = 1;
   localparam int P_INIT = 2;
   localparam int P_RUN  = 3;
   localparam int P_DONE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_ctrl_if #(.CNT_W(CNT_W), .STEP_W(STEP_W), .DWELL_W(DWELL_W)) bus ();

   seq_ctrl_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .DWELL_W(DWELL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // RUN progress is tracked as elapsed RUN cycles k; an enable happens on every
   // max(dwell,1)-th cycle, and iter counts enables.
   int m_ph, m_reg, m_len, m_step, m_dwell, m_k, m_iter;
   bit cmp_on = 1'b0;

   function automatic bit m_en();
      int d;
      d = (m_dwell == 0) ? 1 : m_dwell;
      return (m_ph == P_RUN) && (((m_k + 1) % d) == 0);
   endfunction

   always @(posedge clk) begin
      bit en_now;
      en_now = m_en();
      if (rst) begin
         m_ph = P_OFF; m_reg = 0; m_len = 0; m_step = 0; m_dwell = 0; m_k = 0; m_iter = 0;
         cmp_on = 1'b1;
      end else if (m_ph != P_OFF && bus.on == 2'd0) begin
         m_ph = P_OFF; m_reg = 0;
      end else begin
         case (m_ph)
            P_OFF: if (bus.on != 2'd0) begin m_ph = P_IDLE; m_reg = int'(bus.on); end
            P_IDLE: begin
               if (bus.start) begin
                  m_ph = P_INIT; m_len = int'(bus.len); m_step = int'(bus.step_cfg); m_dwell = int'(bus.dwell);
               end else m_reg = int'(bus.on);
            end
            P_INIT: begin
               m_iter = 0; m_k = 0;
               m_ph = (m_len != 0) ? P_RUN : P_DONE;
            end
            P_RUN: begin
               m_k++;
               if (en_now) begin
                  m_iter++;
                  if (m_iter == m_len) m_ph = P_DONE;
               end
            end
            default: begin
`ifdef SEQ_CTRL_AUTO_RESTART_EN
               if (bus.start && int'(bus.on) == m_reg) begin
                  m_ph = P_INIT; m_len = int'(bus.len); m_step = int'(bus.step_cfg); m_dwell = int'(bus.dwell);
               end else m_ph = P_IDLE;
`else
               m_ph = P_IDLE;
`endif
            end
         endcase
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_on) begin
         bit run, ini;
         run = (m_ph == P_RUN);
         ini = (m_ph == P_INIT);
         check("regime",        bus.regime,        m_reg);
         check("active",        bus.active,        run || ini);
         check("done",          bus.done,          m_ph == P_DONE);
         check("y_select_next", bus.y_select_next, run ? m_reg : 0);
         check("s_step",        bus.s_step,        run ? ((m_reg == 2) ? 1 : m_step) : 0);
         check("y_en",          bus.y_en,          ini || m_en());
         check("s_en",          bus.s_en,          ini || m_en());
         check("y_store_x",     bus.y_store_x,     ini);
         check("s_zero",        bus.s_zero,        ini);
         check("s_add",         bus.s_add,         run && m_reg != 3);
         check("iter",          bus.iter,          m_iter);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run(input bit hold);
      bus.start = 1'b1;
      tick(1);
      if (!hold) bus.start = 1'b0;
   endtask

   // Counts negedges until done; cycle 1 is the first one after the start-sampling edge.
   task automatic wait_done(input int max_cyc, output int cyc, output int pulses);
      cyc = 0;
      pulses = 0;
      while (cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (bus.y_en && !bus.y_store_x) pulses++;
         if (bus.done) break;
      end
      check("done_reached", bus.done, 1);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int c, p;
      bus.on = 2'd0; bus.start = 1'b0; bus.len = '0; bus.step_cfg = '0; bus.dwell = '0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_regime", bus.regime, 0);
      check("rst_iter",   bus.iter,   0);
      check("rst_active", bus.active, 0);

      // CNT, len 3, dwell 1
      bus.on = 2'd2; bus.len = 8'd3; bus.dwell = 3'd1; bus.step_cfg = 2'd3;
      tick(1);
      start_run(1'b0);
      wait_done(20, c, p);
      check("cnt_done_cycle", c, 5);
      check("cnt_pulses",     p, 3);
      check("cnt_iter",       bus.iter, 3);
      tick(1);

      // ELIST, step 2, len 2, dwell 3
      bus.on = 2'd1; bus.step_cfg = 2'd2; bus.len = 8'd2; bus.dwell = 3'd3;
      tick(1);
      start_run(1'b0);
      wait_done(30, c, p);
      check("elist_done_cycle", c, 8);
      check("elist_pulses",     p, 2);
      check("elist_iter",       bus.iter, 2);
      check("elist_regime",     bus.regime, 1);
      tick(1);

      // UPDATE, len 0
      bus.on = 2'd3; bus.len = 8'd0; bus.dwell = 3'd2;
      tick(1);
      start_run(1'b0);
      wait_done(10, c, p);
      check("upd_done_cycle", c, 2);
      check("upd_pulses",     p, 0);
      check("upd_iter",       bus.iter, 0);
      tick(1);

      // CNT abort via on=0 mid-RUN
      bus.on = 2'd2; bus.len = 8'd5; bus.dwell = 3'd2;
      tick(1);
      start_run(1'b0);
      tick(3);
      bus.on = 2'd0;
      tick(1);
      @(negedge clk);
      check("abort_regime", bus.regime, 0);
      check("abort_active", bus.active, 0);
      check("abort_done",   bus.done,   0);
      check("abort_iter",   bus.iter,   1);

      // regime change to ELIST mid-RUN is ignored
      bus.on = 2'd2; bus.len = 8'd5; bus.dwell = 3'd1;
      tick(1);
      start_run(1'b0);
      tick(1);
      bus.on = 2'd1;
      wait_done(20, c, p);
      check("ign_done_cycle", c, 6);
      check("ign_pulses",     p, 5);
      check("ign_iter",       bus.iter, 5);
      check("ign_regime",     bus.regime, 2);
      tick(1);

      // reset during RUN at iter 2
      bus.on = 2'd2; bus.len = 8'd5; bus.dwell = 3'd1;
      tick(1);
      start_run(1'b0);
      tick(3);
      @(negedge clk);
      check("pre_rst_iter", bus.iter, 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_iter",   bus.iter,   0);
      check("mid_rst_regime", bus.regime, 0);
      check("mid_rst_active", bus.active, 0);
      check("mid_rst_y_en",   bus.y_en,   0);

      // full-scale len 255 completes without wrap
      bus.on = 2'd2; bus.len = 8'd255; bus.dwell = 3'd1;
      tick(1);
      start_run(1'b0);
      wait_done(300, c, p);
      check("max_done_cycle", c, 257);
      check("max_pulses",     p, 255);
      check("max_iter",       bus.iter, 255);
      tick(1);

      // start held across DONE
      bus.len = 8'd1; bus.dwell = 3'd1;
      tick(1);
      start_run(1'b1);
      wait_done(10, c, p);
      check("hold_done_cycle", c, 3);
      tick(1);
      @(negedge clk);
`ifdef SEQ_CTRL_AUTO_RESTART_EN
      check("hold_restart_active", bus.active, 1);
      check("hold_restart_store",  bus.y_store_x, 1);
      bus.start = 1'b0;
      wait_done(10, c, p);
      check("hold_restart_done_cycle", c, 2);
`else
      check("hold_no_restart_active", bus.active, 0);
      bus.start = 1'b0;
      tick(2);
      check("hold_idle_active", bus.active, 0);
      check("hold_idle_done",   bus.done,   0);
`endif
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
